zigzag_rle_encoder: RTL

ZIGZAG_RLE_ENCODER -- requirements
Module: zigzag_rle_encoder

---
 rtl/jpeg_rle_pkg.sv | 19 +
 rtl/jpeg_size_category.sv | 58 +++++
 rtl/zigzag_rle_encoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/jpeg_rle_pkg.sv
// Shared types and symbol constants for the zigzag run-length encoder.
package jpeg_rle_pkg;

  localparam int RUN_W  = 4;
  localparam int SIZE_W = 4;

  localparam logic [RUN_W-1:0]  ZRL_RUN  = 4'd15;
  localparam logic [SIZE_W-1:0] ZRL_SIZE = 4'd0;
  localparam logic [RUN_W-1:0]  EOB_RUN  = 4'd0;
  localparam logic [SIZE_W-1:0] EOB_SIZE = 4'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DC      = 2'd1,
    AC_SCAN = 2'd2,
    EOB     = 2'd3
  } state_t;

endpackage

// File: rtl/jpeg_size_category.sv
// Combinational size category and amplitude bits for a signed value one bit
// wider than a coefficient, so a DC difference fits without overflow.
import jpeg_rle_pkg::*;

module jpeg_size_category #(
  parameter int DATA_WIDTH = 15
) (
  input  logic signed [DATA_WIDTH:0]   value,
  output logic        [SIZE_W-1:0]     size,
  output logic        [DATA_WIDTH-1:0] amp
);

  localparam logic [DATA_WIDTH:0]   ONE_W  = (DATA_WIDTH+1)'(1);
  localparam logic [DATA_WIDTH-1:0] ONE_DW = DATA_WIDTH'(1);

  logic [DATA_WIDTH:0]   mag_s;
  logic [DATA_WIDTH-1:0] vm1_s;
  logic [DATA_WIDTH-1:0] mask_s;
  logic [5:0]            cnt_s;

  // Magnitude bit count, saturated size, and one's-complement style amplitude for negatives
  always_comb begin
    if (value[DATA_WIDTH]) begin
      mag_s = ~value + ONE_W;
    end else begin
      mag_s = value;
    end
    cnt_s = 6'd0;
    for (int i = 0; i <= DATA_WIDTH; i++) begin
      if (mag_s[i]) begin
        cnt_s = 6'(i + 1);
      end else begin
        cnt_s = cnt_s;
      end
    end
    if (cnt_s > 6'd15) begin
      size = 4'd15;
    end else begin
      size = cnt_s[3:0];
    end
    mask_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(size)) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
    // Only the low size bits survive, so the low half of (v-1) is enough
    vm1_s = value[DATA_WIDTH-1:0] - ONE_DW;
    if (value[DATA_WIDTH]) begin
      amp = vm1_s & mask_s;
    end else begin
      amp = value[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/zigzag_rle_encoder.sv
// Zigzag block to (run, size, amplitude) symbol stream encoder.
// Optional DC prediction is enabled by defining JPEG_RLE_DC_DIFF_EN.
import jpeg_rle_pkg::*;

module zigzag_rle_encoder #(
  parameter int DATA_WIDTH  = 15,
  parameter int PIXEL_COUNT = 64
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] zz_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              dc_pred_clr,
  output logic                              sym_valid,
  input  logic                              sym_ready,
  output logic [RUN_W-1:0]                  sym_run,
  output logic [SIZE_W-1:0]                 sym_size,
  output logic [DATA_WIDTH-1:0]             sym_amp,
  output logic                              sym_is_dc,
  output logic                              sym_last
);

  localparam logic [5:0] LAST_IDX    = 6'd63;
  localparam logic [5:0] RUN_ZRL_MIN = 6'd16;

  state_t                            state_r, state_n_s;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] blk_r;
  logic [5:0]                        idx_r, idx_n_s, run_r, run_n_s;
  logic                              accept_s, advance_s, in_ready_n_s;
  logic                              sym_valid_n_s, sym_is_dc_n_s, sym_last_n_s;
  logic [RUN_W-1:0]                  sym_run_n_s;
  logic [SIZE_W-1:0]                 sym_size_n_s, cat_size_s;
  logic [DATA_WIDTH-1:0]             sym_amp_n_s, cat_amp_s, coef_s, dc_s;
  logic signed [DATA_WIDTH:0]        dc_diff_s, cat_in_s;

  assign accept_s  = in_valid & in_ready;
  assign advance_s = ~sym_valid | sym_ready;
  assign dc_s      = zz_in[DATA_WIDTH-1:0];
  assign coef_s    = blk_r[32'(idx_r)*DATA_WIDTH +: DATA_WIDTH];

`ifdef JPEG_RLE_DC_DIFF_EN
  logic [DATA_WIDTH-1:0] pred_r, pred_use_s;

  assign pred_use_s = dc_pred_clr ? {DATA_WIDTH{1'b0}} : pred_r;
  assign dc_diff_s  = $signed({dc_s[DATA_WIDTH-1], dc_s})
                    - $signed({pred_use_s[DATA_WIDTH-1], pred_use_s});

  // Predictor follows the last accepted DC; a clear on the accept cycle is already in pred_use_s
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      pred_r <= dc_s;
    end else if (dc_pred_clr) begin
      pred_r <= {DATA_WIDTH{1'b0}};
    end else begin
      pred_r <= pred_r;
    end
  end
`else
  logic unused_clr_s;

  assign unused_clr_s = dc_pred_clr;
  assign dc_diff_s    = $signed({dc_s[DATA_WIDTH-1], dc_s});
`endif

  // The single categoriser sees the incoming DC while idle, else the scanned coefficient
  assign cat_in_s = (state_r == IDLE) ? dc_diff_s : $signed({coef_s[DATA_WIDTH-1], coef_s});

  jpeg_size_category #(.DATA_WIDTH(DATA_WIDTH)) u_size_cat (
    .value (cat_in_s),
    .size  (cat_size_s),
    .amp   (cat_amp_s)
  );

  // Next-state and output-register load decisions
  always_comb begin
    state_n_s     = state_r;
    idx_n_s       = idx_r;
    run_n_s       = run_r;
    sym_valid_n_s = sym_valid & ~sym_ready;
    sym_run_n_s   = sym_run;
    sym_size_n_s  = sym_size;
    sym_amp_n_s   = sym_amp;
    sym_is_dc_n_s = sym_is_dc;
    sym_last_n_s  = sym_last;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          sym_valid_n_s = 1'b1;
          sym_run_n_s   = 4'd0;
          sym_size_n_s  = cat_size_s;
          sym_amp_n_s   = cat_amp_s;
          sym_is_dc_n_s = 1'b1;
          sym_last_n_s  = 1'b0;
          state_n_s     = DC;
        end else begin
          state_n_s = IDLE;
        end
      end
      DC: begin
        idx_n_s   = 6'd1;
        run_n_s   = 6'd0;
        state_n_s = AC_SCAN;
      end
      AC_SCAN: begin
        if (!advance_s) begin
          state_n_s = AC_SCAN;
        end else if (coef_s == {DATA_WIDTH{1'b0}}) begin
          run_n_s = run_r + 6'd1;
          if (idx_r == LAST_IDX) begin
            state_n_s = EOB;
          end else begin
            idx_n_s = idx_r + 6'd1;
          end
        end else if (run_r >= RUN_ZRL_MIN) begin
          // Index is held so the same coefficient is examined again
          sym_valid_n_s = 1'b1;
          sym_run_n_s   = ZRL_RUN;
          sym_size_n_s  = ZRL_SIZE;
          sym_amp_n_s   = {DATA_WIDTH{1'b0}};
          sym_is_dc_n_s = 1'b0;
          sym_last_n_s  = 1'b0;
          run_n_s       = run_r - RUN_ZRL_MIN;
        end else begin
          sym_valid_n_s = 1'b1;
          sym_run_n_s   = run_r[RUN_W-1:0];
          sym_size_n_s  = cat_size_s;
          sym_amp_n_s   = cat_amp_s;
          sym_is_dc_n_s = 1'b0;
          run_n_s       = 6'd0;
          if (idx_r == LAST_IDX) begin
            sym_last_n_s = 1'b1;
            state_n_s    = IDLE;
          end else begin
            sym_last_n_s = 1'b0;
            idx_n_s      = idx_r + 6'd1;
          end
        end
      end
      EOB: begin
        if (advance_s) begin
          sym_valid_n_s = 1'b1;
          sym_run_n_s   = EOB_RUN;
          sym_size_n_s  = EOB_SIZE;
          sym_amp_n_s   = {DATA_WIDTH{1'b0}};
          sym_is_dc_n_s = 1'b0;
          sym_last_n_s  = 1'b1;
          run_n_s       = 6'd0;
          state_n_s     = IDLE;
        end else begin
          state_n_s = EOB;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
    in_ready_n_s = (state_n_s == IDLE) & ~sym_valid_n_s;
  end

  // State, block store and registered symbol outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      blk_r     <= {(DATA_WIDTH*PIXEL_COUNT){1'b0}};
      idx_r     <= 6'd0;
      run_r     <= 6'd0;
      in_ready  <= 1'b0;
      sym_valid <= 1'b0;
      sym_run   <= {RUN_W{1'b0}};
      sym_size  <= {SIZE_W{1'b0}};
      sym_amp   <= {DATA_WIDTH{1'b0}};
      sym_is_dc <= 1'b0;
      sym_last  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      if (accept_s) begin
        blk_r <= zz_in;
      end else begin
        blk_r <= blk_r;
      end
      idx_r     <= idx_n_s;
      run_r     <= run_n_s;
      in_ready  <= in_ready_n_s;
      sym_valid <= sym_valid_n_s;
      sym_run   <= sym_run_n_s;
      sym_size  <= sym_size_n_s;
      sym_amp   <= sym_amp_n_s;
      sym_is_dc <= sym_is_dc_n_s;
      sym_last  <= sym_last_n_s;
    end
  end

endmodule
